cic_channel_arbiter: RTL and testbench
======================================

# cic_channel_arbiter

Shares one downstream sample consumer (post-CIC FIR / packetiser) among CHANNELS independent `cic` decimator instances. Each CIC's `out_strobe`/`out_data` pulse is captured in a one-deep per-channel holding register. A round-robin scheduler drains the holding registers into a single valid/ready output stream tagged with the channel number. Overruns, where a channel produces a new sample before the previous one was granted, are detected and flagged.

## Interface
Parameters:
- CHANNELS, 4, number of CIC channels sharing the consumer (2..16)
- DATA_WIDTH, 20, sample width; matches the CIC OUT_WIDTH (IN_WIDTH 18 + 2)
- CHAN_WIDTH, $clog2(CHANNELS), width of the channel tag

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- in_strobe  in  CHANNELS  bit i = `out_strobe` of CIC i; single-cycle pulse
- in_data  in  CHANNELS*DATA_WIDTH  flat bus; channel i is at [i*DATA_WIDTH +: DATA_WIDTH], signed
- out_valid  out  1  output sample present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_WIDTH  granted sample, signed, unmodified
- out_chan  out  CHAN_WIDTH  channel index of out_data
- overrun  out  CHANNELS  sticky per-channel overrun flags
- clear_overrun  in  1  synchronous clear of all overrun bits

## Operation
- Per channel i: `hold_data[i]` and `pending[i]`. When in_strobe[i] is high, in_data slice i is loaded and pending[i] is set.
- Output slot: out_valid/out_data/out_chan are registered. The slot is free when !out_valid, or when out_valid && out_ready in the current cycle.
- Scheduler, evaluated each cycle the slot is free and any pending bit is set: grant the first pending channel searching upward from (last_grant+1) mod CHANNELS, with wrap-around. On the grant: load the slot, clear pending[g], and set last_grant <= g.
- Simultaneous in_strobe[g] and grant of g: the new sample is captured, pending[g] stays 1, and no overrun is raised.
- in_strobe[i] with pending[i]=1 and no grant of i that cycle: the new sample overwrites the old one (newest wins) and overrun[i] is set.
- clear_overrun takes priority over a coincident set, so the bit reads 0 the next cycle.
- Back-pressure: while out_valid && !out_ready, the slot holds out_data and out_chan stable. Pending channels keep accumulating samples.
- No arithmetic; data passes bit-exact.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, overrun=0, all pending=0, hold_data=0, last_grant=CHANNELS-1 so that channel 0 wins first.
- Latency: in_strobe[i] high in cycle n, slot free → out_valid high in cycle n+2 with that sample.
- Throughput: one sample per clock when out_ready is held high. Back-to-back grants rotate across channels.
- Fairness: any pending channel is granted within CHANNELS slot-free cycles.
- Reset mid-operation: all pending samples and the output slot are discarded immediately. No out_valid appears until new strobes arrive.
- out_ready is ignored while out_valid=0.

## Configuration
- `CIC_ARB_OVERRUN_EN` defined: overrun detection, sticky `overrun` flags and `clear_overrun` are present as described.
- Macro undefined: `overrun` is tied to 0 and `clear_overrun` is ignored. Overwrite-on-pending behaviour is unchanged.

## Structure
- Package `cic_arb_pkg`: default DATA_WIDTH constant (20), maximum CHANNELS (16), and a function returning the next round-robin index.
- One sub-module, `cic_rr_arbiter`: inputs are the pending vector and last_grant; outputs are a one-hot grant, the grant index and grant_valid. It is purely combinational.
- The top level holds the holding registers, pending and overrun flags, the output slot and the last_grant register.

## Test plan
- Single channel: CHANNELS=4, in_strobe=4'b0100, data 20'h12345, out_ready=1 → two cycles later out_valid=1, out_chan=2, out_data=20'h12345 for one cycle.
- All four strobe in the same cycle, data 1,2,3,4, out_ready=1 → out_chan 0,1,2,3 on consecutive cycles with data 1,2,3,4; no overrun.
- Back-pressure: channel 1 pending, out_ready=0 for 10 cycles → out_data/out_chan stable. Channel 1 strobes again with 20'hABCDE → overrun=4'b0010. After out_ready is raised, the next channel-1 output is 20'hABCDE.
- Simultaneous grant and strobe on channel 3 → both samples emerge in order and overrun[3] stays 0.
- Fairness: channels 0 and 1 strobe every cycle, out_ready=1 → out_chan alternates 0,1,0,1. Then clear_overrun → overrun=0 the next cycle.
- Reset asserted with three channels pending and out_valid=1 → out_valid=0 immediately and no output after release until a new strobe arrives. Rebuild without CIC_ARB_OVERRUN_EN → overrun is always 0.

Source files
------------

// File: rtl/cic_arb_pkg.sv
// ---------------------------------------------------------------------------
// cic_arb_pkg
// Shared constants and helpers for the CIC channel arbiter.
//   CIC_ARB_DATA_WIDTH   : default sample width (CIC OUT_WIDTH = 18 + 2)
//   CIC_ARB_MAX_CHANNELS : largest supported channel count
//   rr_next()            : next round-robin index with wrap-around
// ---------------------------------------------------------------------------
package cic_arb_pkg;

    localparam int CIC_ARB_DATA_WIDTH   = 20;
    localparam int CIC_ARB_MAX_CHANNELS = 16;

    // Returns (idx + 1) mod n for idx in [0, n-1].
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        if (idx + 32'd1 >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cic_rr_arbiter
// Purely combinational round-robin picker. Searches the pending vector
// upward from (last_grant + 1) with wrap-around and returns the first hit.
// Ports:
//   pending     in  CHANNELS    request vector
//   last_grant  in  CHAN_WIDTH  most recently granted channel
//   grant_oh    out CHANNELS    one-hot grant (all zero when nothing pending)
//   grant_idx   out CHAN_WIDTH  binary index of the grant
//   grant_valid out 1           some channel was granted
// ---------------------------------------------------------------------------
module cic_rr_arbiter
    import cic_arb_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int CHAN_WIDTH = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0]   pending,
    input  logic [CHAN_WIDTH-1:0] last_grant,
    output logic [CHANNELS-1:0]   grant_oh,
    output logic [CHAN_WIDTH-1:0] grant_idx,
    output logic                  grant_valid
);

    // Walk CHANNELS candidates starting after last_grant; first pending one wins.
    always_comb begin
        int unsigned           cand_v;
        logic [CHAN_WIDTH-1:0] cand_idx_v;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_v      = 32'(last_grant);
        cand_idx_v  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand_v     = rr_next(cand_v, CHANNELS);
            cand_idx_v = CHAN_WIDTH'(cand_v);
            if (!grant_valid && pending[cand_idx_v]) begin
                grant_valid          = 1'b1;
                grant_idx            = cand_idx_v;
                grant_oh[cand_idx_v] = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/cic_channel_arbiter.sv
// ---------------------------------------------------------------------------
// cic_channel_arbiter
// Shares one downstream sample consumer among CHANNELS CIC decimators.
// Each CIC strobe is captured in a one-deep holding register; a round-robin
// scheduler drains them into a registered valid/ready stream tagged with the
// channel index. Newest sample wins when a channel strobes while still
// pending; with CIC_ARB_OVERRUN_EN defined that event sets a sticky flag.
// Ports:
//   clock, reset   single clock, asynchronous active-high reset
//   in_strobe      per-channel CIC out_strobe pulses
//   in_data        flat bus, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready/out_data/out_chan   granted sample stream
//   overrun        sticky per-channel overrun flags (0 without the macro)
//   clear_overrun  synchronous clear of all overrun flags
// Build option: `CIC_ARB_OVERRUN_EN enables overrun detection.
// ---------------------------------------------------------------------------
module cic_channel_arbiter
    import cic_arb_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = CIC_ARB_DATA_WIDTH,
    parameter int CHAN_WIDTH = $clog2(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            in_strobe,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CHAN_WIDTH-1:0]          out_chan,
    output logic [CHANNELS-1:0]            overrun,
    input  logic                           clear_overrun
);

    logic [DATA_WIDTH-1:0] hold_data_r [CHANNELS];
    logic [CHANNELS-1:0]   pending_r;
    logic [CHAN_WIDTH-1:0] last_grant_r;
    logic [CHANNELS-1:0]   grant_oh_s;
    logic [CHAN_WIDTH-1:0] grant_idx_s;
    logic                  grant_valid_s;
    logic                  slot_free_s;
    logic                  fire_s;

    cic_rr_arbiter #(
        .CHANNELS   (CHANNELS),
        .CHAN_WIDTH (CHAN_WIDTH)
    ) u_rr (
        .pending     (pending_r),
        .last_grant  (last_grant_r),
        .grant_oh    (grant_oh_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // The slot can take a new sample when empty or being consumed this cycle.
    always_comb begin
        slot_free_s = !out_valid || out_ready;
        fire_s      = slot_free_s && grant_valid_s;
    end

    // Holding registers and pending flags; a strobe always wins over a
    // coincident grant so the freshly captured sample stays pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_strobe[i]) begin
                    hold_data_r[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                    pending_r[i]   <= 1'b1;
                end else if (fire_s && grant_oh_s[i]) begin
                    pending_r[i]   <= 1'b0;
                end else begin
                    pending_r[i]   <= pending_r[i];
                end
            end
        end
    end

    // Output slot and round-robin pointer; the granted sample is read from the
    // holding register before any coincident strobe overwrites it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_chan     <= '0;
            last_grant_r <= CHAN_WIDTH'(CHANNELS - 1);
        end else if (fire_s) begin
            out_valid    <= 1'b1;
            out_data     <= hold_data_r[grant_idx_s];
            out_chan     <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end else begin
            out_valid    <= out_valid;
        end
    end

`ifdef CIC_ARB_OVERRUN_EN
    logic [CHANNELS-1:0] overrun_r;

    // Sticky overrun: strobe on a pending channel that is not granted now.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_r <= '0;
        end else if (clear_overrun) begin
            overrun_r <= '0;
        end else begin
            overrun_r <= overrun_r | (in_strobe & pending_r & ~(grant_oh_s & {CHANNELS{fire_s}}));
        end
    end

    assign overrun = overrun_r;
`else
    logic unused_clear_s;

    assign unused_clear_s = clear_overrun;
    assign overrun        = '0;
`endif

endmodule

// File: tb/tb_cic_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cic_channel_arbiter
// Directed stimulus for cic_channel_arbiter (CHANNELS=4). Expected output
// samples are queued as stimulus is issued; a monitor pops and compares on
// every out_valid && out_ready handshake.
// ---------------------------------------------------------------------------
module tb_cic_channel_arbiter;

    localparam int CH = 4;
    localparam int DW = 20;
    localparam int CW = 2;

`ifdef CIC_ARB_OVERRUN_EN
    localparam logic [CH-1:0] OVR_BP   = 4'b0010;
    localparam logic [CH-1:0] OVR_FAIR = 4'b0011;
`else
    localparam logic [CH-1:0] OVR_BP   = 4'b0000;
    localparam logic [CH-1:0] OVR_FAIR = 4'b0000;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [CH-1:0]    in_strobe;
    logic [CH*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_chan;
    logic [CH-1:0]    overrun;
    logic             clear_overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [CW+DW-1:0] exp_q [$];

    always #5 clock = ~clock;

    cic_channel_arbiter #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .CHAN_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_strobe     (in_strobe),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [CH-1:0] mask, input logic [DW-1:0] d0,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        in_data   = {d3, d2, d1, d0};
        in_strobe = mask;
        tick();
        in_strobe = '0;
    endtask

    task automatic expect_out(input logic [CW-1:0] chan, input logic [DW-1:0] data);
        exp_q.push_back({chan, data});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: compare every accepted sample against the queue head.
    always @(negedge clock) begin
        logic [CW+DW-1:0] e;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL mon_unexpected: got chan %0d data %0h expected no output", out_chan, out_data);
            end else begin
                e = exp_q.pop_front();
                check("mon_chan", 32'(out_chan), 32'(e[CW+DW-1:DW]));
                check("mon_data", 32'(out_data), 32'(e[DW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        in_strobe     = '0;
        in_data       = '0;
        out_ready     = 1'b1;
        clear_overrun = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_data",    32'(out_data),  32'd0);
        check("rst_chan",    32'(out_chan),  32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        reset = 1'b0;
        tick();

        // Single channel, two-cycle latency, one-cycle output
        expect_out(2'd2, 20'h12345);
        pulse(4'b0100, 20'h0, 20'h0, 20'h12345, 20'h0);
        check("lat_early_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_chan",  32'(out_chan),  32'd2);
        check("lat_data",  32'(out_data),  32'h12345);
        tick();
        check("lat_single_cycle", 32'(out_valid), 32'd0);
        drain("single_drain");

        // All four at once from a fresh pointer: 0,1,2,3 back to back
        do_reset();
        expect_out(2'd0, 20'd1);
        expect_out(2'd1, 20'd2);
        expect_out(2'd2, 20'd3);
        expect_out(2'd3, 20'd4);
        pulse(4'b1111, 20'd1, 20'd2, 20'd3, 20'd4);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("burst_valid", 32'(out_valid), 32'd1);
            tick();
        end
        check("burst_end_valid", 32'(out_valid), 32'd0);
        drain("burst_drain");
        check("burst_overrun", 32'(overrun), 32'd0);

        // Back-pressure with overwrite of a pending channel-1 sample
        out_ready = 1'b0;
        expect_out(2'd1, 20'h11111);
        expect_out(2'd1, 20'hABCDE);
        pulse(4'b0010, 20'h0, 20'h11111, 20'h0, 20'h0);
        pulse(4'b0010, 20'h0, 20'h22222, 20'h0, 20'h0);
        pulse(4'b0010, 20'h0, 20'hABCDE, 20'h0, 20'h0);
        check("bp_overrun", 32'(overrun), 32'(OVR_BP));
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_chan",  32'(out_chan),  32'd1);
            check("bp_data",  32'(out_data),  32'h11111);
            tick();
        end
        out_ready = 1'b1;
        drain("bp_drain");
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("bp_clear", 32'(overrun), 32'd0);

        // Strobe on channel 3 in the same cycle it is granted
        expect_out(2'd3, 20'h33333);
        expect_out(2'd3, 20'h44444);
        pulse(4'b1000, 20'h0, 20'h0, 20'h0, 20'h33333);
        pulse(4'b1000, 20'h0, 20'h0, 20'h0, 20'h44444);
        drain("simul_drain");
        check("simul_overrun", 32'(overrun), 32'd0);

        // Fairness: channels 0 and 1 strobe every cycle, grants alternate
        expect_out(2'd0, 20'h0A000);
        expect_out(2'd1, 20'h0B001);
        expect_out(2'd0, 20'h0A002);
        expect_out(2'd1, 20'h0B003);
        expect_out(2'd0, 20'h0A004);
        expect_out(2'd1, 20'h0B005);
        expect_out(2'd0, 20'h0A005);
        for (int k = 0; k < 6; k++) begin
            pulse(4'b0011, 20'h0A000 + 20'(k), 20'h0B000 + 20'(k), 20'h0, 20'h0);
        end
        drain("fair_drain");
        check("fair_overrun", 32'(overrun), 32'(OVR_FAIR));
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("fair_clear", 32'(overrun), 32'd0);

        // Reset with three channels pending and the slot full
        out_ready = 1'b0;
        pulse(4'b0111, 20'h00001, 20'h00002, 20'h00003, 20'h0);
        tick();
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mid_idle_valid", 32'(out_valid), 32'd0);
        end
        expect_out(2'd1, 20'h55555);
        pulse(4'b0010, 20'h0, 20'h55555, 20'h0, 20'h0);
        drain("mid_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
